// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: opcode constants, retirement classes and halt-FSM encoding.
// Reused by the decode core and the retirement monitor.
package riscv_pkg;

    localparam logic [6:0] OP_ALU_R  = 7'b0110011;
    localparam logic [6:0] OP_ALU_I  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        CLS_ALU_R,
        CLS_ALU_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_AUIPC,
        CLS_UNKNOWN
    } ret_class_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_ARMED,
        ST_HALTED
    } halt_state_t;

endpackage

// File: rtl/riscv_ret_classify.sv
// Combinational opcode-to-class map for retiring instructions.
// Flags any opcode outside the supported RV32I base set as unknown.
module riscv_ret_classify
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    output ret_class_t ret_class,
    output logic       unknown
);

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        ret_class = CLS_UNKNOWN;
        unknown   = 1'b0;
        case (opcode)
            OP_ALU_R:  ret_class = CLS_ALU_R;
            OP_ALU_I:  ret_class = CLS_ALU_I;
            OP_LOAD:   ret_class = CLS_LOAD;
            OP_STORE:  ret_class = CLS_STORE;
            OP_BRANCH: ret_class = CLS_BRANCH;
            OP_JAL:    ret_class = CLS_JAL;
            OP_JALR:   ret_class = CLS_JALR;
            OP_LUI:    ret_class = CLS_LUI;
            OP_AUIPC:  ret_class = CLS_AUIPC;
            default:   unknown   = 1'b1;
        endcase
    end

endmodule

// File: rtl/riscv_retire_monitor.sv
// Retirement monitor: counts retired instructions, publishes each result and
// detects the end-of-program pair. All outputs are registered.
module riscv_retire_monitor
    import riscv_pkg::*;
#(
    parameter logic [31:0] HALT_INST0 = 32'h00c00093,
    parameter logic [31:0] HALT_INST1 = 32'h00008067,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        RET_VALID,
    input  logic [31:0] RET_INST,
    input  logic        RET_RF_WE,
    input  logic [31:0] RET_RF_WD,
    input  logic [11:0] RET_MEM_ADDR,
    input  logic        RET_BR_TAKEN,
    output logic [31:0] NUM_INST,
    output logic [31:0] OUTPUT_PORT,
    output logic        HALT,
    output logic        ERR
);

    halt_state_t          state, state_next;
    ret_class_t           ret_class;
    logic                 unknown;
    logic                 accept;
    logic [CNT_WIDTH-1:0] count_q;
    logic [31:0]          result_q, result_next;
    logic                 halt_q, err_q;

    riscv_ret_classify u_classify (
        .opcode    (RET_INST[6:0]),
        .ret_class (ret_class),
        .unknown   (unknown)
    );

    assign accept = RET_VALID && (state != ST_HALTED);

    always_comb begin
        state_next = state;
        if (accept) begin
            case (state)
                ST_RUN: begin
                    if (RET_INST == HALT_INST0) state_next = ST_ARMED;
                end
                ST_ARMED: begin
                    if (RET_INST == HALT_INST1)      state_next = ST_HALTED;
                    else if (RET_INST == HALT_INST0) state_next = ST_ARMED;
                    else                             state_next = ST_RUN;
                end
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        result_next = result_q;
        case (ret_class)
            CLS_ALU_R, CLS_ALU_I, CLS_LOAD, CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC:
                result_next = RET_RF_WE ? RET_RF_WD : 32'h0;
            CLS_STORE:  result_next = {20'h0, RET_MEM_ADDR};
            CLS_BRANCH: result_next = {31'h0, RET_BR_TAKEN};
            default:    result_next = result_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state    <= ST_RUN;
            count_q  <= '0;
            result_q <= 32'h0;
            halt_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state  <= state_next;
            // HALT gets its own flop so the output is not decoded from the state bits.
            halt_q <= (state_next == ST_HALTED);
            if (accept) begin
                count_q  <= count_q + CNT_WIDTH'(1);
                result_q <= result_next;
                if (unknown) err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        NUM_INST                = 32'h0;
        NUM_INST[CNT_WIDTH-1:0] = count_q;
    end

    assign OUTPUT_PORT = result_q;
    assign HALT        = halt_q;
    assign ERR         = err_q;

endmodule

// File: tb/tb_riscv_retire_monitor.sv
// Self-checking bench for riscv_retire_monitor: a reference model pushes expected
// outputs to a scoreboard as each cycle is driven; they are popped after the edge.
`timescale 1ns/1ps
module tb_riscv_retire_monitor;

    localparam logic [31:0] H0      = 32'h00c00093;
    localparam logic [31:0] H1      = 32'h00008067;
    localparam logic [31:0] I_ADDI  = 32'h00100093;
    localparam logic [31:0] I_ADD   = 32'h002081b3;
    localparam logic [31:0] I_SW    = 32'h00112623;
    localparam logic [31:0] I_BEQ   = 32'h00208463;
    localparam logic [31:0] I_LW    = 32'h0000a103;
    localparam logic [31:0] I_BAD   = 32'h0000007f;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        RET_VALID = 1'b0;
    logic [31:0] RET_INST = 32'h0;
    logic        RET_RF_WE = 1'b0;
    logic [31:0] RET_RF_WD = 32'h0;
    logic [11:0] RET_MEM_ADDR = 12'h0;
    logic        RET_BR_TAKEN = 1'b0;

    logic [31:0] NUM_INST, OUTPUT_PORT, NUM_INST4, OUTPUT_PORT4;
    logic        HALT, ERR, HALT4, ERR4;

    riscv_retire_monitor dut (
        .CLK(CLK), .RSTn(RSTn), .RET_VALID(RET_VALID), .RET_INST(RET_INST),
        .RET_RF_WE(RET_RF_WE), .RET_RF_WD(RET_RF_WD), .RET_MEM_ADDR(RET_MEM_ADDR),
        .RET_BR_TAKEN(RET_BR_TAKEN), .NUM_INST(NUM_INST), .OUTPUT_PORT(OUTPUT_PORT),
        .HALT(HALT), .ERR(ERR)
    );

    riscv_retire_monitor #(.CNT_WIDTH(4)) dut4 (
        .CLK(CLK), .RSTn(RSTn), .RET_VALID(RET_VALID), .RET_INST(RET_INST),
        .RET_RF_WE(RET_RF_WE), .RET_RF_WD(RET_RF_WD), .RET_MEM_ADDR(RET_MEM_ADDR),
        .RET_BR_TAKEN(RET_BR_TAKEN), .NUM_INST(NUM_INST4), .OUTPUT_PORT(OUTPUT_PORT4),
        .HALT(HALT4), .ERR(ERR4)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] num;
        logic [31:0] out;
        logic        halt;
        logic        err;
        logic [31:0] num4;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model state: 0 = run, 1 = armed, 2 = halted.
    int          m_state = 0;
    logic [31:0] m_count = 32'h0;
    logic [31:0] m_out = 32'h0;
    logic        m_err = 1'b0;

    task automatic model_reset();
        m_state = 0;
        m_count = 32'h0;
        m_out   = 32'h0;
        m_err   = 1'b0;
    endtask

    task automatic model_step();
        exp_t e;
        if (RET_VALID && m_state != 2) begin
            m_count = m_count + 32'h1;
            case (RET_INST[6:0])
                7'b0110011, 7'b0010011, 7'b0000011, 7'b1101111,
                7'b1100111, 7'b0110111, 7'b0010111:
                    m_out = RET_RF_WE ? RET_RF_WD : 32'h0;
                7'b0100011: m_out = {20'h0, RET_MEM_ADDR};
                7'b1100011: m_out = {31'h0, RET_BR_TAKEN};
                default:    m_err = 1'b1;
            endcase
            if (m_state == 0)
                m_state = (RET_INST == H0) ? 1 : 0;
            else if (RET_INST == H1)
                m_state = 2;
            else
                m_state = (RET_INST == H0) ? 1 : 0;
        end
        e.num  = m_count;
        e.out  = m_out;
        e.halt = (m_state == 2);
        e.err  = m_err;
        e.num4 = {28'h0, m_count[3:0]};
        sb.push_back(e);
    endtask

    // Advances one clock and scores the DUT outputs against the oldest expectation.
    task automatic step_and_score(input string tag);
        exp_t e;
        model_step();
        @(posedge CLK);
        #1;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            if (NUM_INST !== e.num || OUTPUT_PORT !== e.out || HALT !== e.halt ||
                ERR !== e.err || NUM_INST4 !== e.num4 || HALT4 !== e.halt) begin
                failures++;
                $display("FAIL %s: got num=%h out=%h halt=%b err=%b num4=%h halt4=%b want num=%h out=%h halt=%b err=%b num4=%h",
                         tag, NUM_INST, OUTPUT_PORT, HALT, ERR, NUM_INST4, HALT4,
                         e.num, e.out, e.halt, e.err, e.num4);
            end
        end
        RET_VALID = 1'b0;
    endtask

    task automatic retire(input string tag, input logic [31:0] inst, input logic we,
                          input logic [31:0] wd, input logic [11:0] addr, input logic br);
        RET_VALID    = 1'b1;
        RET_INST     = inst;
        RET_RF_WE    = we;
        RET_RF_WD    = wd;
        RET_MEM_ADDR = addr;
        RET_BR_TAKEN = br;
        step_and_score(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            RET_VALID = 1'b0;
            RET_INST  = $urandom();
            RET_RF_WD = $urandom();
            step_and_score(tag);
        end
    endtask

    task automatic do_reset();
        RSTn = 1'b0;
        RET_VALID = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #2;
        RSTn = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (NUM_INST !== 32'h0 || OUTPUT_PORT !== 32'h0 || HALT !== 1'b0 || ERR !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: got num=%h out=%h halt=%b err=%b want all zero",
                     NUM_INST, OUTPUT_PORT, HALT, ERR);
        end
    endtask

    task automatic test_alu();
        retire("alu_addi", I_ADDI, 1'b1, 32'h0000_0f00, 12'h0, 1'b0);
        retire("alu_add", I_ADD, 1'b1, 32'hdead_beef, 12'h0, 1'b0);
        retire("load_no_we", I_LW, 1'b0, 32'h1234_5678, 12'h0, 1'b0);
        retire("load_we", I_LW, 1'b1, 32'h1234_5678, 12'h0, 1'b0);
    endtask

    task automatic test_store_branch_bubble();
        logic [31:0] start;
        start = NUM_INST;
        retire("store", I_SW, 1'b0, 32'hffff_ffff, 12'heec, 1'b1);
        retire("branch_taken", I_BEQ, 1'b0, 32'hffff_ffff, 12'h123, 1'b1);
        idle("bubble", 3);
        checks++;
        if (NUM_INST !== start + 32'd2) begin
            failures++;
            $display("FAIL bubble_count: got %0d want %0d", NUM_INST, start + 32'd2);
        end
        retire("branch_not_taken", I_BEQ, 1'b1, 32'hffff_ffff, 12'h0, 1'b0);
    endtask

    task automatic test_unknown();
        retire("pre_unknown", I_ADDI, 1'b1, 32'h0000_0055, 12'h0, 1'b0);
        retire("unknown_op", I_BAD, 1'b1, 32'h9999_9999, 12'h777, 1'b1);
        retire("after_unknown", I_ADD, 1'b1, 32'h0000_0066, 12'h0, 1'b0);
    endtask

    task automatic test_halt_gap();
        do_reset();
        retire("pre_halt", I_ADD, 1'b1, 32'h0000_0011, 12'h0, 1'b0);
        retire("halt0", H0, 1'b1, 32'h0000_000c, 12'h0, 1'b0);
        idle("halt_gap", 2);
        retire("halt1", H1, 1'b1, 32'h0000_0abc, 12'h0, 1'b0);
        checks++;
        if (HALT !== 1'b1 || NUM_INST !== 32'd3) begin
            failures++;
            $display("FAIL halt_edge: got halt=%b num=%0d want halt=1 num=3", HALT, NUM_INST);
        end
        retire("halted_add", I_ADD, 1'b1, 32'h5555_5555, 12'h0, 1'b0);
        retire("halted_bad", I_BAD, 1'b1, 32'h5555_5555, 12'h0, 1'b0);
        retire("halted_store", I_SW, 1'b0, 32'h0, 12'h321, 1'b0);
    endtask

    task automatic test_broken_halt();
        do_reset();
        retire("broken_h0", H0, 1'b1, 32'h0000_000c, 12'h0, 1'b0);
        retire("broken_add", I_ADD, 1'b1, 32'h0000_0022, 12'h0, 1'b0);
        retire("broken_h1", H1, 1'b1, 32'h0000_0033, 12'h0, 1'b0);
        retire("rep_h0a", H0, 1'b1, 32'h0000_000c, 12'h0, 1'b0);
        retire("rep_h0b", H0, 1'b1, 32'h0000_000c, 12'h0, 1'b0);
        retire("rep_h1", H1, 1'b1, 32'h0000_0044, 12'h0, 1'b0);
    endtask

    task automatic test_async_reset();
        do_reset();
        retire("pre_rst_a", I_ADDI, 1'b1, 32'h0000_0777, 12'h0, 1'b0);
        retire("pre_rst_b", I_BAD, 1'b1, 32'h0, 12'h0, 1'b0);
        RET_VALID = 1'b1;
        RET_INST  = I_ADD;
        RET_RF_WE = 1'b1;
        RET_RF_WD = 32'hcafe_f00d;
        #2;
        RSTn = 1'b0;
        #1;
        checks++;
        if (NUM_INST !== 32'h0 || OUTPUT_PORT !== 32'h0 || HALT !== 1'b0 || ERR !== 1'b0 ||
            NUM_INST4 !== 32'h0) begin
            failures++;
            $display("FAIL async_reset: got num=%h out=%h halt=%b err=%b num4=%h want all zero",
                     NUM_INST, OUTPUT_PORT, HALT, ERR, NUM_INST4);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (NUM_INST !== 32'h0 || OUTPUT_PORT !== 32'h0) begin
            failures++;
            $display("FAIL reset_hold: got num=%h out=%h want zero", NUM_INST, OUTPUT_PORT);
        end
        RET_VALID = 1'b0;
        model_reset();
        #2;
        RSTn = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 17; i++)
            retire("wrap_step", I_ADDI, 1'b1, 32'(i), 12'h0, 1'b0);
        checks++;
        if (NUM_INST4 !== 32'd1 || NUM_INST !== 32'd17) begin
            failures++;
            $display("FAIL wrap: got num4=%0d num=%0d want num4=1 num=17", NUM_INST4, NUM_INST);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store_branch_bubble();
        test_unknown();
        test_halt_gap();
        test_broken_halt();
        test_async_reset();
        test_wrap();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
